// File: rtl/huffman_decoder.sv
// Serial Huffman decoder: six mask/codeword table entries, MSB-first bit accumulation.
// Define HUFF_DEC_HIST_EN to add per-symbol decode counters on HIST1..HIST6.
module huffman_decoder (
  input  logic       clk,
  input  logic       reset,
  input  logic       code_valid,
  input  logic [7:0] HC1,
  input  logic [7:0] HC2,
  input  logic [7:0] HC3,
  input  logic [7:0] HC4,
  input  logic [7:0] HC5,
  input  logic [7:0] HC6,
  input  logic [7:0] M1,
  input  logic [7:0] M2,
  input  logic [7:0] M3,
  input  logic [7:0] M4,
  input  logic [7:0] M5,
  input  logic [7:0] M6,
  input  logic       bit_in,
  input  logic       bit_valid,
  input  logic       bit_last,
  output logic [7:0] gray_data,
  output logic       gray_valid,
  output logic       err,
  output logic       done,
  output logic       ready
`ifdef HUFF_DEC_HIST_EN
  ,
  output logic [7:0] HIST1,
  output logic [7:0] HIST2,
  output logic [7:0] HIST3,
  output logic [7:0] HIST4,
  output logic [7:0] HIST5,
  output logic [7:0] HIST6
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READY  = 2'd1,
    DECODE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [5:0][7:0] hc_q, hc_d;
  logic [5:0][7:0] m_q, m_d;
  logic [6:0]      acc_q, acc_d;
  logic [2:0]      len_q, len_d;
  logic [7:0]      gray_data_q, gray_data_d;
  logic            gray_valid_q, gray_valid_d;
  logic            err_q, err_d;
  logic            done_q, done_d;

  logic [7:0]      acc_next;
  logic [3:0]      len_next;
  logic            hit;
  logic [2:0]      hit_idx;
  logic            load;

`ifdef HUFF_DEC_HIST_EN
  logic [5:0][7:0] hist_q, hist_d;
`endif

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] c;
    c = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      c = c + {3'b000, v[i]};
    end
    return c;
  endfunction

  always_comb begin
    acc_next = {acc_q, bit_in};
    len_next = {1'b0, len_q} + 4'd1;
  end

  // Scan entries from 1 upward so the lowest matching index wins.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int unsigned k = 0; k < 6; k++) begin
      if (!hit && (m_q[k] != '0) && (len_next == popcount8(m_q[k])) &&
          ((acc_next & m_q[k]) == (hc_q[k] & m_q[k]))) begin
        hit     = 1'b1;
        hit_idx = 3'(k);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    hc_d         = hc_q;
    m_d          = m_q;
    acc_d        = acc_q;
    len_d        = len_q;
    gray_data_d  = gray_data_q;
    gray_valid_d = 1'b0;
    err_d        = 1'b0;
    done_d       = 1'b0;
    load         = 1'b0;

    case (state_q)
      IDLE: begin
        if (code_valid) load = 1'b1;
      end
      READY, DECODE: begin
        if (code_valid && (state_q == READY)) begin
          load = 1'b1;
        end else if (bit_valid) begin
          if (hit) begin
            gray_valid_d = 1'b1;
            gray_data_d  = {5'b00000, hit_idx + 3'd1};
            done_d       = bit_last;
            acc_d        = '0;
            len_d        = '0;
            state_d      = READY;
          end else if ((len_next == 4'd8) || bit_last) begin
            // Overlong code or stream ending on a partial code.
            err_d   = 1'b1;
            done_d  = bit_last;
            acc_d   = '0;
            len_d   = '0;
            state_d = READY;
          end else begin
            acc_d   = acc_next[6:0];
            len_d   = len_next[2:0];
            state_d = DECODE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      hc_d    = {HC6, HC5, HC4, HC3, HC2, HC1};
      m_d     = {M6, M5, M4, M3, M2, M1};
      acc_d   = '0;
      len_d   = '0;
      state_d = READY;
    end
  end

`ifdef HUFF_DEC_HIST_EN
  always_comb begin
    hist_d = hist_q;
    if (load) begin
      hist_d = '0;
    end else if (gray_valid_d) begin
      for (int unsigned k = 0; k < 6; k++) begin
        if (hit_idx == 3'(k)) hist_d[k] = hist_q[k] + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) hist_q <= '0;
    else       hist_q <= hist_d;
  end

  assign HIST1 = hist_q[0];
  assign HIST2 = hist_q[1];
  assign HIST3 = hist_q[2];
  assign HIST4 = hist_q[3];
  assign HIST5 = hist_q[4];
  assign HIST6 = hist_q[5];
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      hc_q         <= '0;
      m_q          <= '0;
      acc_q        <= '0;
      len_q        <= '0;
      gray_data_q  <= '0;
      gray_valid_q <= 1'b0;
      err_q        <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      hc_q         <= hc_d;
      m_q          <= m_d;
      acc_q        <= acc_d;
      len_q        <= len_d;
      gray_data_q  <= gray_data_d;
      gray_valid_q <= gray_valid_d;
      err_q        <= err_d;
      done_q       <= done_d;
    end
  end

  assign gray_data  = gray_data_q;
  assign gray_valid = gray_valid_q;
  assign err        = err_q;
  assign done       = done_q;
  assign ready      = (state_q != IDLE);

endmodule

// File: tb/tb_huffman_decoder.sv
// Scoreboard bench for huffman_decoder: a bit-level reference decoder predicts every cycle's outputs.
module tb_huffman_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       code_valid = 1'b0;
  logic       bit_in = 1'b0;
  logic       bit_valid = 1'b0;
  logic       bit_last = 1'b0;
  logic [7:0] hc_t [6];
  logic [7:0] m_t [6];
  logic [7:0] HC1, HC2, HC3, HC4, HC5, HC6;
  logic [7:0] M1, M2, M3, M4, M5, M6;
  logic [7:0] gray_data;
  logic       gray_valid, err, done, ready;
`ifdef HUFF_DEC_HIST_EN
  logic [7:0] HIST1, HIST2, HIST3, HIST4, HIST5, HIST6;
`endif

  assign HC1 = hc_t[0]; assign HC2 = hc_t[1]; assign HC3 = hc_t[2];
  assign HC4 = hc_t[3]; assign HC5 = hc_t[4]; assign HC6 = hc_t[5];
  assign M1 = m_t[0]; assign M2 = m_t[1]; assign M3 = m_t[2];
  assign M4 = m_t[3]; assign M5 = m_t[4]; assign M6 = m_t[5];

  huffman_decoder dut (
    .clk(clk), .reset(reset), .code_valid(code_valid),
    .HC1(HC1), .HC2(HC2), .HC3(HC3), .HC4(HC4), .HC5(HC5), .HC6(HC6),
    .M1(M1), .M2(M2), .M3(M3), .M4(M4), .M5(M5), .M6(M6),
    .bit_in(bit_in), .bit_valid(bit_valid), .bit_last(bit_last),
    .gray_data(gray_data), .gray_valid(gray_valid), .err(err), .done(done), .ready(ready)
`ifdef HUFF_DEC_HIST_EN
    , .HIST1(HIST1), .HIST2(HIST2), .HIST3(HIST3), .HIST4(HIST4), .HIST5(HIST5), .HIST6(HIST6)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       gv;
    logic [7:0] gd;
    logic       er;
    logic       dn;
    logic       rdy;
  } exp_t;

  exp_t sbq[$];

  int n_vec = 0;
  int n_err = 0;

  // Reference decoder state: code value/length per entry, shift accumulator.
  int unsigned ref_code [6];
  int unsigned ref_len [6];
  int unsigned ref_acc;
  int unsigned ref_cnt;
  int          ref_state;   // 0 no table, 1 empty accumulator, 2 partial code
  logic [7:0]  ref_gray;
  int unsigned ref_hist [6];

  task automatic expect_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  task automatic ref_reset();
    ref_state = 0; ref_acc = 0; ref_cnt = 0; ref_gray = 8'h00;
    for (int i = 0; i < 6; i++) begin
      ref_code[i] = 0; ref_len[i] = 0; ref_hist[i] = 0;
    end
  endtask

  task automatic set_std_table();
    hc_t[0] = 8'h00; m_t[0] = 8'h01;
    hc_t[1] = 8'h02; m_t[1] = 8'h03;
    hc_t[2] = 8'h06; m_t[2] = 8'h07;
    hc_t[3] = 8'h0E; m_t[3] = 8'h0F;
    hc_t[4] = 8'h1E; m_t[4] = 8'h1F;
    hc_t[5] = 8'h1F; m_t[5] = 8'h1F;
  endtask

  // One clock: drive inputs, predict outputs, then compare after the edge.
  task automatic step(input logic cv, input logic bv, input logic b, input logic last);
    exp_t e;
    int   sym;
    @(negedge clk);
    code_valid = cv; bit_valid = bv; bit_in = b; bit_last = last;
    e.gv = 1'b0; e.er = 1'b0; e.dn = 1'b0;
    if (cv && ref_state != 2) begin
      for (int i = 0; i < 6; i++) begin
        int unsigned n;
        n = 0;
        for (int j = 0; j < 8; j++) if (m_t[i][j]) n++;
        ref_len[i]  = n;
        ref_code[i] = 32'(hc_t[i] & m_t[i]);
        ref_hist[i] = 0;
      end
      ref_acc = 0; ref_cnt = 0; ref_state = 1;
    end else if (bv && ref_state != 0) begin
      ref_acc = (ref_acc << 1) | 32'(b);
      ref_cnt++;
      sym = 0;
      for (int i = 0; i < 6; i++) begin
        if (sym == 0 && ref_len[i] != 0 && ref_len[i] == ref_cnt &&
            (ref_acc % (32'd1 << ref_len[i])) == ref_code[i]) sym = i + 1;
      end
      if (sym != 0) begin
        e.gv = 1'b1; ref_gray = 8'(sym); e.dn = last;
        ref_hist[sym-1] = (ref_hist[sym-1] + 1) % 256;
        ref_acc = 0; ref_cnt = 0; ref_state = 1;
      end else if (ref_cnt == 8 || last) begin
        e.er = 1'b1; e.dn = last;
        ref_acc = 0; ref_cnt = 0; ref_state = 1;
      end else begin
        ref_state = 2;
      end
    end
    e.gd  = ref_gray;
    e.rdy = (ref_state != 0);
    sbq.push_back(e);
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      expect_eq("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      exp_t x;
      x = sbq.pop_front();
      expect_eq("gray_valid", 32'(gray_valid), 32'(x.gv));
      expect_eq("gray_data",  32'(gray_data),  32'(x.gd));
      expect_eq("err",        32'(err),        32'(x.er));
      expect_eq("done",       32'(done),       32'(x.dn));
      expect_eq("ready",      32'(ready),      32'(x.rdy));
    end
  endtask

  task automatic bit_step(input logic b, input logic last);
    step(1'b0, 1'b1, b, last);
  endtask

  task automatic idle_step();
    step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    code_valid = 1'b0; bit_valid = 1'b0; bit_last = 1'b0;
    #2 reset = 1'b1;
    #1;
    ref_reset();
    expect_eq("rst_gray_valid", 32'(gray_valid), 32'd0);
    expect_eq("rst_gray_data",  32'(gray_data),  32'd0);
    expect_eq("rst_err",        32'(err),        32'd0);
    expect_eq("rst_done",       32'(done),       32'd0);
    expect_eq("rst_ready",      32'(ready),      32'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    ref_reset();
    set_std_table();
    #1;
    expect_eq("rst_gray_valid", 32'(gray_valid), 32'd0);
    expect_eq("rst_gray_data",  32'(gray_data),  32'd0);
    expect_eq("rst_ready",      32'(ready),      32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Bits ignored before any table is loaded
    bit_step(1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);

    // 0 | 10 | 110 -> 1, 2, 3
    bit_step(1'b0, 1'b0); bit_step(1'b1, 1'b0); bit_step(1'b0, 1'b0);
    bit_step(1'b1, 1'b0); bit_step(1'b1, 1'b0); bit_step(1'b0, 1'b0);
    idle_step();

    // 11111 | 11110(last) -> 6, then 5 with done
    for (int i = 0; i < 5; i++) bit_step(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) bit_step(1'b1, 1'b0);
    bit_step(1'b0, 1'b1);
    idle_step();

    // Partial code at end of stream: err and done together
    bit_step(1'b1, 1'b0); bit_step(1'b1, 1'b1);
    idle_step();

    // Entry 6 disabled: eight ones overflow, then 0 decodes as 1
    m_t[5] = 8'h00;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) bit_step(1'b1, 1'b0);
    bit_step(1'b0, 1'b0);
    idle_step();
    set_std_table();
    step(1'b1, 1'b0, 1'b0, 1'b0);

    // Reset mid-code discards partial bits and table
    bit_step(1'b1, 1'b0); bit_step(1'b1, 1'b0);
    pulse_reset();
    bit_step(1'b0, 1'b0); bit_step(1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    bit_step(1'b0, 1'b0);
    idle_step();

    // Load request while a code is partial is ignored
    bit_step(1'b1, 1'b0);
    hc_t[1] = 8'h03;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    bit_step(1'b0, 1'b0);
    set_std_table();
    idle_step();

    // Random contiguous and gapped streams
    for (int i = 0; i < 300; i++) begin
      step(1'b0, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 15) == 0));
    end
    idle_step();

`ifdef HUFF_DEC_HIST_EN
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 256; i++) bit_step(1'b0, 1'b0);
    bit_step(1'b1, 1'b0); bit_step(1'b0, 1'b0);
    idle_step();
    expect_eq("hist1_wrap", 32'(HIST1), ref_hist[0]);
    expect_eq("hist2",      32'(HIST2), ref_hist[1]);
    expect_eq("hist1_abs",  32'(HIST1), 32'd0);
    expect_eq("hist2_abs",  32'(HIST2), 32'd1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    expect_eq("hist1_clr", 32'(HIST1), 32'd0);
    expect_eq("hist2_clr", 32'(HIST2), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/huffman_decoder.md
HUFFMAN_DECODER -- requirements
Module: huffman_decoder

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; reset  in  1  asynchronous active-high reset.
REQ-002 SHALL have ports: code_valid  in  1  one-cycle pulse loading the code table from HC1..HC6/M1..M6.
REQ-003 SHALL have ports: HC1..HC6  in  8 each  codewords, right-aligned, MSB-first order; M1..M6  in  8 each  masks, contiguous ones from LSB, popcount = code length.
REQ-004 SHALL have ports: bit_in  in  1  serial code bit; bit_valid  in  1  bit_in qualifier; bit_last  in  1  marks final bit of stream, valid only with bit_valid.
REQ-005 SHALL have ports: gray_data  out  8  decoded symbol 1..6, zero-extended; gray_valid  out  1  one-cycle symbol strobe.
REQ-006 SHALL have ports: err  out  1  one-cycle invalid-code pulse; done  out  1  one-cycle end-of-stream pulse; ready  out  1  high when a table is loaded.

Function
REQ-007 SHALL implement FSM states IDLE (no table), READY (table loaded, accumulator empty), DECODE (accumulator holds 1..7 bits).
REQ-008 SHALL register all six HC/M pairs on code_valid in IDLE or READY, then enter READY; code_valid in DECODE SHALL be ignored.
REQ-009 SHALL ignore bit_valid in IDLE; no outputs change.
REQ-010 On each bit_valid in READY/DECODE SHALL form acc_next = {acc[6:0], bit_in}, len_next = len + 1.
REQ-011 Entry k SHALL match when M_k != 0, len_next == popcount(M_k), and (acc_next & M_k) == (HC_k & M_k); when several entries match, the lowest k SHALL win.
REQ-012 On match SHALL assert gray_valid with gray_data = k on the cycle after the completing bit (1-cycle latency), clear acc/len, go to READY.
REQ-013 With no match and len_next == 8 SHALL pulse err on the next cycle, clear acc/len, go to READY; the bit stream continues with the next bit.
REQ-014 With no match and len_next < 8 SHALL go to / stay in DECODE with no output pulse.
REQ-015 When bit_last accompanies the bit SHALL pulse done in the same cycle as that bit's gray_valid/err; if the bit leaves a partial code (len_next 1..7, no match), err SHALL also pulse; accumulator SHALL clear and the FSM SHALL go to READY.
REQ-016 gray_data SHALL hold its last value between strobes; gray_valid and err SHALL never assert in the same cycle, except err with done per REQ-015.
REQ-017 ready SHALL be 1 in READY and DECODE, 0 in IDLE.
REQ-018 Back-to-back bit_valid on every cycle SHALL be sustained with no stall; no backpressure exists.

Reset
REQ-019 reset SHALL asynchronously force IDLE, acc=0, len=0, all HC/M registers=0, gray_data=0, gray_valid=0, err=0, done=0, ready=0.
REQ-020 reset asserted mid-DECODE SHALL discard the partial code and the table; no strobe SHALL follow deassertion until a new table and bits arrive.

Configuration
REQ-021 With macro HUFF_DEC_HIST_EN defined SHALL add outputs HIST1..HIST6 (8 bits each, reset 0) counting decoded symbols per k, wrapping 255->0, cleared on code_valid.
REQ-022 Without HUFF_DEC_HIST_EN the HIST ports and counters SHALL be absent; all other behaviour identical.

Verification
Table used unless noted: sym1 '0' (HC=00,M=01), sym2 '10' (02,03), sym3 '110' (06,07), sym4 '1110' (0E,0F), sym5 '11110' (1E,1F), sym6 '11111' (1F,1F).
REQ-023 SHALL test: load table, bits 0,1,0,1,1,0 contiguous -> gray_valid strobes with gray_data 1,2,3, each one cycle after the completing bit.
REQ-024 SHALL test: bits 1,1,1,1,1 then 1,1,1,1,0 with bit_last on final bit -> gray_data 6 then 5; done coincides with the second strobe; FSM in READY.
REQ-025 SHALL test: table with M6=00 and bits 1,1,1,1,1,1,1,1 -> no strobe until the 8th bit, then err one cycle later; next bit 0 -> gray_data 1.
REQ-026 SHALL test: bits 1,1 with bit_last on second bit -> err and done pulse together, no gray_valid.
REQ-027 SHALL test: bits 1,1 then reset pulse, reload table, bit 0 -> single strobe gray_data 1; bit_valid before reload produces nothing.
REQ-028 SHALL test with HUFF_DEC_HIST_EN: 256 decoded sym1 then one sym2 -> HIST1=0, HIST2=1; code_valid clears all HIST to 0.
